// File: rtl/mem_req_ctrl.sv
// L2-side initiator for the ECC-protected main-memory handshake: optional writeback, read, capture, response.
// Optional read-only reissue after an uncorrectable error is compiled in with `define MEM_RETRY_EN.
module mem_req_ctrl #(
   parameter int DW = 128,
   parameter int AW = 3,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic          req_wb,
   input  logic [AW-1:0] req_wb_addr,
   input  logic [DW-1:0] req_wb_data,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [DW-1:0] resp_data,
   output logic          resp_err,
   output logic [CW-1:0] err_count,
   output logic          l2_miss,
   output logic          en_back,
   output logic [AW-1:0] group_id,
   inout  wire  [DW-1:0] data_block,
   input  logic          error_mem
);

   typedef enum logic [2:0] {IDLE, WB, RD, CAP, RESP} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          wb_q, wb_d;
   logic [AW-1:0] wbAddr_q, wbAddr_d;
   logic [DW-1:0] wbData_q, wbData_d;
   logic [DW-1:0] respData_q, respData_d;
   logic          respErr_q, respErr_d;
   logic [CW-1:0] errCount_q, errCount_d;
   logic          respValid_q, respValid_d;
   logic          reqReady_q, reqReady_d;
   logic          l2Miss_q, l2Miss_d;
   logic          enBack_q, enBack_d;
   logic [AW-1:0] groupId_q, groupId_d;
   logic          busDrive_q, busDrive_d;
`ifdef MEM_RETRY_EN
   logic          retryUsed_q, retryUsed_d;
`endif

   // Next-state and next-output logic; every output is registered so it is
   // valid for the whole cycle of the state it belongs to.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wb_d        = wb_q;
      wbAddr_d    = wbAddr_q;
      wbData_d    = wbData_q;
      respData_d  = respData_q;
      respErr_d   = respErr_q;
      errCount_d  = errCount_q;
      respValid_d = respValid_q;
      reqReady_d  = reqReady_q;
      groupId_d   = groupId_q;
      l2Miss_d    = 1'b0;
      enBack_d    = 1'b0;
      busDrive_d  = 1'b0;
`ifdef MEM_RETRY_EN
      retryUsed_d = retryUsed_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid && reqReady_q) begin
               addr_d     = req_addr;
               wb_d       = req_wb;
               wbAddr_d   = req_wb_addr;
               wbData_d   = req_wb_data;
               reqReady_d = 1'b0;
               l2Miss_d   = 1'b1;
`ifdef MEM_RETRY_EN
               retryUsed_d = 1'b0;
`endif
               if (req_wb) begin
                  state_d    = WB;
                  enBack_d   = 1'b1;
                  busDrive_d = 1'b1;
                  groupId_d  = req_wb_addr;
               end else begin
                  state_d   = RD;
                  groupId_d = req_addr;
               end
            end
         end
         // A writeback already pulsed l2_miss, so RD stays quiet to keep the pulse single.
         WB: begin
            state_d   = RD;
            l2Miss_d  = 1'b0;
            groupId_d = addr_q;
         end
         RD: begin
            state_d   = CAP;
            groupId_d = addr_q;
         end
         CAP: begin
`ifdef MEM_RETRY_EN
            if (error_mem && !retryUsed_q) begin
               state_d     = RD;
               l2Miss_d    = 1'b1;
               retryUsed_d = 1'b1;
            end else
`endif
            begin
               state_d     = RESP;
               respValid_d = 1'b1;
               respData_d  = data_block;
               respErr_d   = error_mem;
               if (error_mem && (errCount_q != {CW{1'b1}}))
                  errCount_d = errCount_q + CW'(1);
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d     = IDLE;
               respValid_d = 1'b0;
               reqReady_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wb_q        <= 1'b0;
         wbAddr_q    <= '0;
         wbData_q    <= '0;
         respData_q  <= '0;
         respErr_q   <= 1'b0;
         errCount_q  <= '0;
         respValid_q <= 1'b0;
         reqReady_q  <= 1'b1;
         l2Miss_q    <= 1'b0;
         enBack_q    <= 1'b0;
         groupId_q   <= '0;
         busDrive_q  <= 1'b0;
`ifdef MEM_RETRY_EN
         retryUsed_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wb_q        <= wb_d;
         wbAddr_q    <= wbAddr_d;
         wbData_q    <= wbData_d;
         respData_q  <= respData_d;
         respErr_q   <= respErr_d;
         errCount_q  <= errCount_d;
         respValid_q <= respValid_d;
         reqReady_q  <= reqReady_d;
         l2Miss_q    <= l2Miss_d;
         enBack_q    <= enBack_d;
         groupId_q   <= groupId_d;
         busDrive_q  <= busDrive_d;
`ifdef MEM_RETRY_EN
         retryUsed_q <= retryUsed_d;
`endif
      end
   end

   // The bus is only ever driven during WB; RD gives the turnaround gap before memory drives in CAP.
   assign data_block = busDrive_q ? wbData_q : {DW{1'bz}};

   assign req_ready  = reqReady_q;
   assign resp_valid = respValid_q;
   assign resp_data  = respData_q;
   assign resp_err   = respErr_q;
   assign err_count  = errCount_q;
   assign l2_miss    = l2Miss_q;
   assign en_back    = enBack_q;
   assign group_id   = groupId_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl: table of directed transactions against a fixed-latency ECC memory model,
// plus backpressure, mid-transaction reset, error-counter saturation and (with MEM_RETRY_EN) retry.
module tb_mem_req_ctrl;

   localparam int DW = 128;
   localparam int AW = 3;
   localparam int CW = 8;

   localparam logic [DW-1:0] LINE0 = 128'hF0F0F0F0_0F0F0F0F_A0A0A0A0_0A0A0A0A;
   localparam logic [DW-1:0] LINE1 = 128'h11111111_22222222_33333333_44444444;
   localparam logic [DW-1:0] LINE3 = 128'h33333333_CCCCCCCC_55555555_AAAAAAAA;
   localparam logic [DW-1:0] LINE5 = 128'h55555555_66666666_77777777_88888888;
   localparam logic [DW-1:0] LINE6 = 128'h66666666_00000000_FFFFFFFF_12121212;
   localparam logic [DW-1:0] LINE7 = 128'h77777777_DEADBEEF_CAFEF00D_01234567;
   localparam logic [DW-1:0] WB2   = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
   localparam logic [DW-1:0] WB4   = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_wb, resp_ready;
   logic          req_ready, resp_valid, resp_err, l2_miss, en_back;
   logic [AW-1:0] req_addr, req_wb_addr, group_id;
   logic [DW-1:0] req_wb_data, resp_data;
   logic [CW-1:0] err_count;
   logic          error_mem;
   wire  [DW-1:0] data_block;

   mem_req_ctrl #(.DW(DW), .AW(AW), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_err(resp_err), .err_count(err_count),
      .l2_miss(l2_miss), .en_back(en_back), .group_id(group_id),
      .data_block(data_block), .error_mem(error_mem)
   );

   always #5 clk = ~clk;

   // Memory model: 0 clean, 1 single-bit (returned corrected), 2 persistent double, 3 double on first read only.
   logic [DW-1:0] memLine [8];
   logic [1:0]    memErr  [8];
   int            capDelay;
   logic          memDrive;
   logic [DW-1:0] memOut;

   always_comb begin
      memDrive  = (capDelay == 1);
      memOut    = '0;
      error_mem = 1'b0;
      if (memDrive) begin
         if (memErr[group_id] >= 2'd2) begin
            memOut    = memLine[group_id] ^ 128'h3;
            error_mem = 1'b1;
         end else begin
            memOut = memLine[group_id];
         end
      end
   end

   assign data_block = memDrive ? memOut : {DW{1'bz}};

   // Write commits at the l2_miss edge; read data appears one cycle later, or two after a writeback.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         capDelay = 0;
      end else begin
         if (memDrive && memErr[group_id] == 2'd3) memErr[group_id] = 2'd0;
         if (capDelay > 0) capDelay = capDelay - 1;
         if (l2_miss) begin
            if (en_back) begin
               memLine[group_id] = data_block;
               memErr[group_id]  = 2'd0;
               capDelay = 2;
            end else begin
               capDelay = 1;
            end
         end
      end
   end

   int   l2Pulses = 0;
   int   consecutive = 0;
   logic prevMiss = 1'b0;

   always @(posedge clk) begin
      if (l2_miss) begin
         l2Pulses = l2Pulses + 1;
         if (prevMiss) consecutive = consecutive + 1;
      end
      prevMiss = l2_miss;
   end

   typedef struct {
      logic [AW-1:0] addr;
      logic          wb;
      logic [AW-1:0] wbAddr;
      logic [DW-1:0] wbData;
      logic [DW-1:0] expData;
      logic          expErr;
      logic [CW-1:0] expCount;
      int            expLat;
      int            expPulses;
   } vec_t;

   vec_t vecs [6];
   int   checks = 0;
   int   errors = 0;

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issues one request, waits (bounded) for the response and completes the handshake.
   task automatic applyStimulus(input vec_t v, output int lat, output int pulses,
                                output logic [DW-1:0] data, output logic err, output logic [CW-1:0] cnt);
      int start;
      @(negedge clk);
      req_addr    = v.addr;
      req_wb      = v.wb;
      req_wb_addr = v.wbAddr;
      req_wb_data = v.wbData;
      req_valid   = 1'b1;
      start       = l2Pulses;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat = lat + 1;
      end
      data = resp_data;
      err  = resp_err;
      cnt  = err_count;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      pulses = l2Pulses - start;
   endtask

   int            lat, pulses;
   logic [DW-1:0] data;
   logic          err;
   logic [CW-1:0] cnt;
   vec_t          v;

   initial begin
      vecs[0] = '{3'd0, 1'b0, 3'd0, '0,  LINE0,          1'b0, 8'd0, 3, 1};
      vecs[1] = '{3'd2, 1'b1, 3'd2, WB2, WB2,            1'b0, 8'd0, 4, 1};
      vecs[2] = '{3'd1, 1'b0, 3'd0, '0,  LINE1,          1'b0, 8'd0, 3, 1};
`ifdef MEM_RETRY_EN
      vecs[3] = '{3'd3, 1'b0, 3'd0, '0,  LINE3 ^ 128'h3, 1'b1, 8'd1, 5, 2};
`else
      vecs[3] = '{3'd3, 1'b0, 3'd0, '0,  LINE3 ^ 128'h3, 1'b1, 8'd1, 3, 1};
`endif
      vecs[4] = '{3'd5, 1'b1, 3'd4, WB4, LINE5,          1'b0, 8'd1, 4, 1};
      vecs[5] = '{3'd4, 1'b0, 3'd0, '0,  WB4,            1'b0, 8'd1, 3, 1};

      for (int i = 0; i < 8; i++) begin
         memLine[i] = '0;
         memErr[i]  = 2'd0;
      end
      memLine[0] = LINE0; memLine[1] = LINE1; memLine[3] = LINE3;
      memLine[5] = LINE5; memLine[6] = LINE6; memLine[7] = LINE7;
      memErr[1]  = 2'd1;
      memErr[3]  = 2'd2;

      reset = 1'b1;
      req_valid = 1'b0; req_wb = 1'b0; req_addr = '0; req_wb_addr = '0; req_wb_data = '0;
      resp_ready = 1'b0;
      #12;
      checkOutput("rst_req_ready",  DW'(req_ready),  DW'(1'b1));
      checkOutput("rst_resp_valid", DW'(resp_valid), DW'(1'b0));
      checkOutput("rst_l2_miss",    DW'(l2_miss),    DW'(1'b0));
      checkOutput("rst_en_back",    DW'(en_back),    DW'(1'b0));
      checkOutput("rst_group_id",   DW'(group_id),   DW'(3'd0));
      checkOutput("rst_err_count",  DW'(err_count),  DW'(8'd0));
      checkOutput("rst_resp_data",  resp_data,       '0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i], lat, pulses, data, err, cnt);
         checkOutput($sformatf("v%0d_data", i),    data,        vecs[i].expData);
         checkOutput($sformatf("v%0d_err", i),     DW'(err),    DW'(vecs[i].expErr));
         checkOutput($sformatf("v%0d_count", i),   DW'(cnt),    DW'(vecs[i].expCount));
         checkOutput($sformatf("v%0d_latency", i), DW'(lat),    DW'(vecs[i].expLat));
         checkOutput($sformatf("v%0d_pulses", i),  DW'(pulses), DW'(vecs[i].expPulses));
      end

      // Backpressure: a new request held during RESP must wait for the handshake.
      @(negedge clk);
      req_addr = 3'd0; req_wb = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_addr = 3'd5;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat = lat + 1;
      end
      pulses = l2Pulses;
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("bp%0d_valid", c), DW'(resp_valid), DW'(1'b1));
         checkOutput($sformatf("bp%0d_data", c),  resp_data,       LINE0);
         checkOutput($sformatf("bp%0d_ready", c), DW'(req_ready),  DW'(1'b0));
         @(posedge clk);
         #1;
      end
      checkOutput("bp_no_issue", DW'(l2Pulses - pulses), DW'(0));
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      checkOutput("bp_valid_drop", DW'(resp_valid), DW'(1'b0));
      checkOutput("bp_ready_back", DW'(req_ready),  DW'(1'b1));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checkOutput("bp_accept_miss", DW'(l2_miss),  DW'(1'b1));
      checkOutput("bp_accept_gid",  DW'(group_id), DW'(3'd5));
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat = lat + 1;
      end
      checkOutput("bp_second_data", resp_data, LINE5);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;

      // Asynchronous reset while in RD.
      @(negedge clk);
      req_addr = 3'd6; req_wb = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_l2_miss",    DW'(l2_miss),    DW'(1'b0));
      checkOutput("mid_rst_group_id",   DW'(group_id),   DW'(3'd0));
      checkOutput("mid_rst_req_ready",  DW'(req_ready),  DW'(1'b1));
      checkOutput("mid_rst_resp_valid", DW'(resp_valid), DW'(1'b0));
      checkOutput("mid_rst_err_count",  DW'(err_count),  DW'(8'd0));
      checkOutput("mid_rst_resp_data",  resp_data,       '0);
      @(negedge clk);
      reset = 1'b0;
      v = '{3'd6, 1'b0, 3'd0, '0, LINE6, 1'b0, 8'd0, 3, 1};
      applyStimulus(v, lat, pulses, data, err, cnt);
      checkOutput("post_rst_data",    data,     LINE6);
      checkOutput("post_rst_latency", DW'(lat), DW'(3));
      checkOutput("post_rst_count",   DW'(cnt), DW'(8'd0));

      // Error counter saturation: 256 uncorrectable fills.
      v = '{3'd3, 1'b0, 3'd0, '0, LINE3 ^ 128'h3, 1'b1, 8'd0, 3, 1};
      for (int n = 0; n < 256; n++) begin
         applyStimulus(v, lat, pulses, data, err, cnt);
         if (n == 0) checkOutput("sat_first", DW'(cnt), DW'(8'd1));
         if (n == 254) checkOutput("sat_255", DW'(cnt), DW'(8'd255));
      end
      checkOutput("sat_hold",     DW'(err_count), DW'(8'd255));
      checkOutput("sat_last_err", DW'(err),       DW'(1'b1));

`ifdef MEM_RETRY_EN
      memErr[7] = 2'd3;
      v = '{3'd7, 1'b0, 3'd0, '0, LINE7, 1'b0, 8'd255, 5, 2};
      applyStimulus(v, lat, pulses, data, err, cnt);
      checkOutput("retry_data",    data,        LINE7);
      checkOutput("retry_err",     DW'(err),    DW'(1'b0));
      checkOutput("retry_pulses",  DW'(pulses), DW'(2));
      checkOutput("retry_latency", DW'(lat),    DW'(5));
`endif

      checkOutput("l2_miss_gap", DW'(consecutive), DW'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
